// File: rtl/fp_pkg.sv
// Shared single-precision adder constants: all-ones exponent, GRS bit
// indices and packed-result field positions used across the adder stages.
package fp_pkg;

  localparam int MENT_WIDTH   = 23;
  localparam int EXPO_WIDTH   = 8;
  localparam int CNT_WIDTH    = 16;
  localparam int RESULT_WIDTH = MENT_WIDTH + EXPO_WIDTH + 1;

  localparam logic [EXPO_WIDTH-1:0] EXPO_MAX = '1;

  localparam int GRS_G = 2;
  localparam int GRS_R = 1;
  localparam int GRS_S = 0;

  // Packed word layout {sign, exponent, fraction}; stage 4 and writeback rely on it.
  localparam int FRAC_LSB = 0;
  localparam int FRAC_MSB = MENT_WIDTH - 1;
  localparam int EXPO_LSB = MENT_WIDTH;
  localparam int EXPO_MSB = MENT_WIDTH + EXPO_WIDTH - 1;
  localparam int SIGN_POS = RESULT_WIDTH - 1;

endpackage

// File: rtl/addition_stage5_round_if.sv
// Stage-5 rounding bus: upstream operand handshake plus downstream result handshake.
interface addition_stage5_round_if
  import fp_pkg::*;
#(
  parameter int MENT_WIDTH = fp_pkg::MENT_WIDTH,
  parameter int EXPO_WIDTH = fp_pkg::EXPO_WIDTH,
  parameter int CNT_WIDTH  = fp_pkg::CNT_WIDTH
);

  logic [MENT_WIDTH-1:0]            normalized_mentissa_in;
  logic [EXPO_WIDTH-1:0]            normalized_exponent_in;
  logic [2:0]                       grs_in;
  logic                             sign_in;
  logic                             valid_in;
  logic                             ready_out;
  logic [MENT_WIDTH+EXPO_WIDTH:0]   result_out;
  logic                             overflow_out;
  logic                             inexact_out;
  logic                             valid_out;
  logic                             ready_in;
  logic [CNT_WIDTH-1:0]             inexact_count_out;

  modport master (
    output normalized_mentissa_in, normalized_exponent_in, grs_in, sign_in,
           valid_in, ready_in,
    input  ready_out, result_out, overflow_out, inexact_out, valid_out,
           inexact_count_out
  );

  modport slave (
    input  normalized_mentissa_in, normalized_exponent_in, grs_in, sign_in,
           valid_in, ready_in,
    output ready_out, result_out, overflow_out, inexact_out, valid_out,
           inexact_count_out
  );

endinterface

// File: rtl/round_nearest_even.sv
// Round-to-nearest-even increment of a fraction given its guard/round/sticky bits.
module round_nearest_even
  import fp_pkg::*;
#(
  parameter int MENT_WIDTH = fp_pkg::MENT_WIDTH
) (
  input  logic [MENT_WIDTH-1:0] frac,
  input  logic [2:0]            grs,
  output logic [MENT_WIDTH:0]   sum,
  output logic                  inexact
);

  logic inc;

  // Ties (G=1, R=S=0) round up only when that makes the LSB even.
  assign inc     = grs[GRS_G] & (grs[GRS_R] | grs[GRS_S] | frac[0]);
  assign sum     = {1'b0, frac} + {{MENT_WIDTH{1'b0}}, inc};
  assign inexact = |grs;

endmodule

// File: rtl/addition_stage5_round.sv
// Adder stage 5: two-register rounding pipeline with valid/ready on both sides,
// carry renormalization, overflow-to-infinity and a saturating inexact counter.
module addition_stage5_round
  import fp_pkg::*;
#(
  parameter int MENT_WIDTH = fp_pkg::MENT_WIDTH,
  parameter int EXPO_WIDTH = fp_pkg::EXPO_WIDTH,
  parameter int CNT_WIDTH  = fp_pkg::CNT_WIDTH
) (
  input logic                    clk_in,
  input logic                    rst_in,
  addition_stage5_round_if.slave bus
);

  localparam logic [EXPO_WIDTH-1:0] EXPO_ALL_ONES = '1;
  localparam logic [EXPO_WIDTH-1:0] EXPO_ONE      = EXPO_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE       = CNT_WIDTH'(1);

  logic adv_a;
  logic adv_b;

  logic                  valid_a_reg;
  logic                  sign_a_reg;
  logic [EXPO_WIDTH-1:0] expo_a_reg;
  logic [MENT_WIDTH:0]   sum_a_reg;
  logic                  inexact_a_reg;
  logic                  special_a_reg;

  logic                           valid_b_reg;
  logic [MENT_WIDTH+EXPO_WIDTH:0] result_reg;
  logic                           overflow_reg;
  logic                           inexact_b_reg;
  logic [CNT_WIDTH-1:0]           count_reg;

  logic [MENT_WIDTH:0]            rne_sum;
  logic                           rne_inexact;
  logic                           special_in;

  logic [EXPO_WIDTH-1:0]          expo_next;
  logic [MENT_WIDTH-1:0]          frac_next;
  logic                           overflow_next;
  logic                           inexact_next;

  round_nearest_even #(.MENT_WIDTH(MENT_WIDTH)) u_rne (
    .frac    (bus.normalized_mentissa_in),
    .grs     (bus.grs_in),
    .sum     (rne_sum),
    .inexact (rne_inexact)
  );

  assign special_in = (bus.normalized_exponent_in == EXPO_ALL_ONES);

  assign adv_b         = !valid_b_reg | bus.ready_in;
  assign adv_a         = !valid_a_reg | adv_b;
  assign bus.ready_out = adv_a;

  // Specials keep their unrounded fraction so NaN payloads pass through intact.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_a_reg   <= 1'b0;
      sign_a_reg    <= 1'b0;
      expo_a_reg    <= '0;
      sum_a_reg     <= '0;
      inexact_a_reg <= 1'b0;
      special_a_reg <= 1'b0;
    end else if (adv_a) begin
      valid_a_reg   <= bus.valid_in;
      sign_a_reg    <= bus.sign_in;
      expo_a_reg    <= bus.normalized_exponent_in;
      sum_a_reg     <= special_in ? {1'b0, bus.normalized_mentissa_in} : rne_sum;
      inexact_a_reg <= rne_inexact & !special_in;
      special_a_reg <= special_in;
    end
  end

  always_comb begin
    expo_next     = expo_a_reg;
    frac_next     = sum_a_reg[MENT_WIDTH-1:0];
    overflow_next = 1'b0;
    inexact_next  = inexact_a_reg;
    if (special_a_reg) begin
      inexact_next = 1'b0;
    end else begin
      if (sum_a_reg[MENT_WIDTH]) begin
        expo_next = expo_a_reg + EXPO_ONE;
        frac_next = '0;
      end
      if (expo_next == EXPO_ALL_ONES) begin
        frac_next     = '0;
        overflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_b_reg   <= 1'b0;
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
      inexact_b_reg <= 1'b0;
    end else if (adv_b) begin
      valid_b_reg   <= valid_a_reg;
      result_reg    <= {sign_a_reg, expo_next, frac_next};
      overflow_reg  <= overflow_next;
      inexact_b_reg <= inexact_next;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_reg <= '0;
    end else if (valid_b_reg && bus.ready_in && inexact_b_reg && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_ONE;
    end
  end

  assign bus.valid_out         = valid_b_reg;
  assign bus.result_out        = result_reg;
  assign bus.overflow_out      = overflow_reg;
  assign bus.inexact_out       = inexact_b_reg;
  assign bus.inexact_count_out = count_reg;

endmodule

// File: tb/tb_addition_stage5_round.sv
// Directed bench for the stage-5 rounding pipeline: rounding cases, stall, async reset.
module tb_addition_stage5_round;
  import fp_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  addition_stage5_round_if bus ();

  addition_stage5_round dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int unsigned cnt_exp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [22:0] frac, input logic [7:0] expo,
                       input logic [2:0] grs, input logic sign, input logic valid);
    bus.normalized_mentissa_in = frac;
    bus.normalized_exponent_in = expo;
    bus.grs_in                 = grs;
    bus.sign_in                = sign;
    bus.valid_in               = valid;
  endtask

  // One isolated transaction with ready_in held high.
  task automatic single(input string tag, input logic [22:0] frac, input logic [7:0] expo,
                        input logic [2:0] grs, input logic sign, input logic [31:0] res,
                        input logic ovf, input logic inx);
    bus.ready_in = 1'b1;
    drive(frac, expo, grs, sign, 1'b1);
    chk({tag, "/ready"}, 64'(bus.ready_out), 64'd1);
    tick();
    bus.valid_in = 1'b0;
    chk({tag, "/lat1"}, 64'(bus.valid_out), 64'd0);
    tick();
    chk({tag, "/valid"}, 64'(bus.valid_out), 64'd1);
    chk({tag, "/result"}, 64'(bus.result_out), 64'(res));
    chk({tag, "/ovf"}, 64'(bus.overflow_out), 64'(ovf));
    chk({tag, "/inexact"}, 64'(bus.inexact_out), 64'(inx));
    $display("txn %s: result=0x%08h ovf=%0b inexact=%0b cnt=%0d",
             tag, bus.result_out, bus.overflow_out, bus.inexact_out, bus.inexact_count_out);
    tick();
    if (inx) cnt_exp++;
    chk({tag, "/count"}, 64'(bus.inexact_count_out), 64'(cnt_exp));
    chk({tag, "/drain"}, 64'(bus.valid_out), 64'd0);
  endtask

  initial begin
    bus.ready_in = 1'b1;
    drive(23'h0, 8'h0, 3'b000, 1'b0, 1'b0);

    #12;
    chk("rst/valid", 64'(bus.valid_out), 64'd0);
    chk("rst/result", 64'(bus.result_out), 64'd0);
    chk("rst/ovf", 64'(bus.overflow_out), 64'd0);
    chk("rst/inexact", 64'(bus.inexact_out), 64'd0);
    chk("rst/count", 64'(bus.inexact_count_out), 64'd0);
    rst_in = 1'b0;

    single("tie_odd",   23'h000001, 8'h80, 3'b100, 1'b0, 32'h40000002, 1'b0, 1'b1);
    single("tie_even",  23'h000002, 8'h80, 3'b100, 1'b0, 32'h40000002, 1'b0, 1'b1);
    single("exact",     23'h000002, 8'h80, 3'b000, 1'b0, 32'h40000002, 1'b0, 1'b0);
    single("carry",     23'h7FFFFF, 8'h7F, 3'b110, 1'b0, 32'h40000000, 1'b0, 1'b1);
    single("overflow",  23'h7FFFFF, 8'hFE, 3'b111, 1'b1, 32'hFF800000, 1'b1, 1'b1);
    single("special",   23'h400000, 8'hFF, 3'b101, 1'b0, 32'h7FC00000, 1'b0, 1'b0);

    // Stream of four inexact operands into a stalled sink.
    bus.ready_in = 1'b0;
    drive(23'h000010, 8'h81, 3'b001, 1'b0, 1'b1);
    tick();
    chk("strm/ready_e1", 64'(bus.ready_out), 64'd1);
    drive(23'h000011, 8'h81, 3'b110, 1'b1, 1'b1);
    tick();
    chk("strm/ready_e2", 64'(bus.ready_out), 64'd0);
    chk("strm/valid_e2", 64'(bus.valid_out), 64'd1);
    chk("strm/r0_e2", 64'(bus.result_out), 64'h40800010);
    drive(23'h123456, 8'h10, 3'b100, 1'b0, 1'b1);
    tick();
    chk("strm/ready_e3", 64'(bus.ready_out), 64'd0);
    chk("strm/r0_stall", 64'(bus.result_out), 64'h40800010);
    chk("strm/cnt_stall", 64'(bus.inexact_count_out), 64'(cnt_exp));
    bus.ready_in = 1'b1;
    #1;
    chk("strm/ready_rel", 64'(bus.ready_out), 64'd1);
    $display("txn strm0: result=0x%08h", bus.result_out);
    tick();
    cnt_exp++;
    drive(23'h000003, 8'h00, 3'b101, 1'b0, 1'b1);
    chk("strm/r1", 64'(bus.result_out), 64'hC0800012);
    $display("txn strm1: result=0x%08h", bus.result_out);
    tick();
    cnt_exp++;
    bus.valid_in = 1'b0;
    chk("strm/r2", 64'(bus.result_out), 64'h08123456);
    $display("txn strm2: result=0x%08h", bus.result_out);
    tick();
    cnt_exp++;
    chk("strm/r3", 64'(bus.result_out), 64'h00000004);
    chk("strm/valid_r3", 64'(bus.valid_out), 64'd1);
    $display("txn strm3: result=0x%08h", bus.result_out);
    tick();
    cnt_exp++;
    chk("strm/drain", 64'(bus.valid_out), 64'd0);
    chk("strm/count", 64'(bus.inexact_count_out), 64'(cnt_exp));

    // Fill both stages, then reset between edges.
    bus.ready_in = 1'b0;
    drive(23'h000005, 8'h90, 3'b111, 1'b0, 1'b1);
    tick();
    tick();
    chk("arst/valid_pre", 64'(bus.valid_out), 64'd1);
    chk("arst/ready_pre", 64'(bus.ready_out), 64'd0);
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst/valid", 64'(bus.valid_out), 64'd0);
    chk("arst/count", 64'(bus.inexact_count_out), 64'd0);
    chk("arst/result", 64'(bus.result_out), 64'd0);
    $display("txn arst: valid=%0b cnt=%0d", bus.valid_out, bus.inexact_count_out);
    #2;
    rst_in = 1'b0;
    bus.valid_in = 1'b0;
    cnt_exp = 0;
    single("post_rst", 23'h000007, 8'h82, 3'b011, 1'b0, 32'h41000007, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
